// File: rtl/csc_mix_formatter.sv
// rtl/csc_mix_formatter.sv - time-multiplexed CSC channel mixer with saturate/wrap output formatting
module csc_mix_formatter #(
  parameter int NUM_INPUT_BITS  = 24,
  parameter int NUM_OUTPUT_BITS = 15,
  parameter int NUM_SIGNALS     = 4,
  parameter int FRAC_DROP       = 9,
  parameter int SATURATE        = 1,
  parameter int CLIP_CNT_BITS   = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_INPUT_BITS*NUM_SIGNALS-1:0] vol_data,
  input  logic [NUM_SIGNALS-1:0]                chan_mask,
  input  logic                                  data_en,
  output logic                                  in_ready,
  output logic [NUM_OUTPUT_BITS-1:0]            csc_data,
  output logic                                  csc_data_en,
  input  logic                                  csc_data_rdy,
  output logic [CLIP_CNT_BITS-1:0]              clip_count,
  output logic                                  overrun
);

  // One extra headroom bit per doubling of channels keeps the running sum exact.
  localparam int IDX_W = $clog2(NUM_SIGNALS);
  localparam int SUM_W = NUM_INPUT_BITS + IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SIGNALS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FORMAT = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [NUM_INPUT_BITS*NUM_SIGNALS-1:0] vol_q;
  logic [NUM_SIGNALS-1:0]                mask_q;
  logic signed [SUM_W-1:0]               acc;
  logic [IDX_W-1:0]                      idx;
  logic [NUM_INPUT_BITS-1:0]             ch_sel;
  logic signed [SUM_W-1:0]               addend;
  logic signed [SUM_W-1:0]               shifted;
  logic                                  in_range;
  logic [NUM_OUTPUT_BITS-1:0]            fmt_data;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_next  = state;
    in_ready    = 1'b0;
    csc_data_en = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (data_en) begin
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (idx == LAST_IDX) begin
          state_next = FORMAT;
        end
      end
      FORMAT: begin
        state_next = OUTPUT;
      end
      OUTPUT: begin
        csc_data_en = 1'b1;
        if (csc_data_rdy) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Channel select for the shared adder, and scaling/range logic for the final sum.
  always_comb begin
    ch_sel  = vol_q[idx*NUM_INPUT_BITS +: NUM_INPUT_BITS];
    addend  = '0;
    if (mask_q[idx]) begin
      addend = {{(SUM_W-NUM_INPUT_BITS){ch_sel[NUM_INPUT_BITS-1]}}, ch_sel};
    end
    shifted = acc >>> FRAC_DROP;
    // The scaled sum fits when every bit from the output sign bit upward agrees.
    in_range = (&shifted[SUM_W-1:NUM_OUTPUT_BITS-1]) |
               ~(|shifted[SUM_W-1:NUM_OUTPUT_BITS-1]);
    fmt_data = shifted[NUM_OUTPUT_BITS-1:0];
    if (!in_range && (SATURATE != 0)) begin
      if (shifted[SUM_W-1]) begin
        fmt_data = {1'b1, {(NUM_OUTPUT_BITS-1){1'b0}}};
      end else begin
        fmt_data = {1'b0, {(NUM_OUTPUT_BITS-1){1'b1}}};
      end
    end
  end

  // Capture, accumulate, format and status bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      vol_q      <= '0;
      mask_q     <= '0;
      acc        <= '0;
      idx        <= '0;
      csc_data   <= '0;
      clip_count <= '0;
      overrun    <= 1'b0;
    end else begin
      // A sample offered while busy is dropped; only the flag records it.
      if (data_en && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (data_en) begin
            vol_q  <= vol_data;
            mask_q <= chan_mask;
            acc    <= '0;
            idx    <= '0;
          end
        end
        ACCUM: begin
          acc <= acc + addend;
          idx <= idx + IDX_W'(1);
        end
        FORMAT: begin
          csc_data <= fmt_data;
          // Clipping is counted in wrap mode too, so the counter reports range loss either way.
          if (!in_range && !(&clip_count)) begin
            clip_count <= clip_count + CLIP_CNT_BITS'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csc_mix_formatter.sv
// tb/tb_csc_mix_formatter.sv - scoreboard bench for csc_mix_formatter (saturating and wrapping builds)
module tb_csc_mix_formatter;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] vol_data;
  logic [3:0]  chan_mask;
  logic        data_en;
  logic        csc_data_rdy;
  logic        in_ready, in_ready_w;
  logic [14:0] csc_data, csc_data_w;
  logic        csc_data_en, csc_data_en_w;
  logic [15:0] clip_count, clip_count_w;
  logic        overrun, overrun_w;

  always #5 clk = ~clk;

  csc_mix_formatter #(.SATURATE(1)) dut (
    .clk(clk), .rst(rst), .vol_data(vol_data), .chan_mask(chan_mask),
    .data_en(data_en), .in_ready(in_ready), .csc_data(csc_data),
    .csc_data_en(csc_data_en), .csc_data_rdy(csc_data_rdy),
    .clip_count(clip_count), .overrun(overrun)
  );

  csc_mix_formatter #(.SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .vol_data(vol_data), .chan_mask(chan_mask),
    .data_en(data_en), .in_ready(in_ready_w), .csc_data(csc_data_w),
    .csc_data_en(csc_data_en_w), .csc_data_rdy(csc_data_rdy),
    .clip_count(clip_count_w), .overrun(overrun_w)
  );

  typedef struct {
    logic [14:0] sat;
    logic [14:0] wr;
    logic [15:0] clip;
    int          acc_cyc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  int          pushed = 0;
  int          out_count = 0;
  logic [15:0] clip_model = 16'h0;
  logic [14:0] last_csc = 15'h0;
  logic [14:0] last_csc_w = 15'h0;
  bit          prev_en = 1'b0;
  bit          rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: exact integer sum, floor-divide by 2^9, then clamp or keep the low 15 bits.
  task automatic model(input logic [95:0] v, input logic [3:0] m,
                       output logic [14:0] sat, output logic [14:0] wr, output bit clip);
    longint sum = 0;
    longint s;
    logic signed [23:0] c;
    for (int i = 0; i < 4; i++) begin
      c = v[i*24 +: 24];
      if (m[i]) sum = sum + longint'(c);
    end
    s = sum >>> 9;
    wr = s[14:0];
    clip = 1'b0;
    if (s > 16383) begin
      sat = 15'h3FFF; clip = 1'b1;
    end else if (s < -16384) begin
      sat = 15'h4000; clip = 1'b1;
    end else begin
      sat = s[14:0];
    end
  endtask

  // Called in the post-edge phase; waits for in_ready and offers one sample.
  task automatic send(input logic [95:0] v, input logic [3:0] m, input bit track);
    exp_t e;
    logic [14:0] s, w;
    bit c;
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
      return;
    end
    vol_data  = v;
    chan_mask = m;
    data_en   = 1'b1;
    if (track) begin
      model(v, m, s, w, c);
      if (c && clip_model != 16'hFFFF) clip_model = clip_model + 16'h1;
      e.sat = s; e.wr = w; e.clip = clip_model; e.acc_cyc = cyc;
      q.push_back(e);
      pushed++;
    end
    @(posedge clk); #1;
    data_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d outputs outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: checks first-valid latency and pops/compares on every accepted output.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_en = 1'b0;
    end else begin
      if (csc_data_en && !prev_en && q.size() > 0)
        chk("latency", cyc - q[0].acc_cyc, 6);
      if (csc_data_en && csc_data_rdy) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_output: got %0h expected none", csc_data);
        end else begin
          e = q.pop_front();
          chk("data_sat", csc_data, e.sat);
          chk("data_wrap", csc_data_w, e.wr);
          chk("clip_sat", clip_count, e.clip);
          chk("clip_wrap", clip_count_w, e.clip);
          last_csc   = csc_data;
          last_csc_w = csc_data_w;
          out_count++;
        end
      end
      prev_en = csc_data_en;
    end
  end

  // Random backpressure, enabled only for the random phase.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) csc_data_rdy = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [95:0] v;
    logic [14:0] exp5;
    logic [23:0] ch;
    int n;

    rst = 1'b1; data_en = 1'b0; vol_data = '0; chan_mask = '0; csc_data_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_in_ready", in_ready, 1);
    chk("rst_data_en", csc_data_en, 0);
    chk("rst_data", csc_data, 0);
    chk("rst_clip", clip_count, 0);
    chk("rst_overrun", overrun, 0);

    send({4{24'h000200}}, 4'hF, 1'b1);
    drain();
    chk("t1_value", last_csc, 15'h0004);
    chk("t1_clip", clip_count, 0);

    send({4{24'h7FFFFF}}, 4'hF, 1'b1);
    drain();
    chk("t2_sat_max", last_csc, 15'h3FFF);
    chk("t3_wrap_max", last_csc_w, 15'h7FFF);
    chk("t3_wrap_clip", clip_count_w, 1);
    send({4{24'h800000}}, 4'hF, 1'b1);
    drain();
    chk("t2_sat_min", last_csc, 15'h4000);
    chk("t2_clip", clip_count, 2);

    send({24'h0, 24'h0, 24'h0, 24'hFFFFFF}, 4'hF, 1'b1);
    drain();
    chk("t4_floor", last_csc, 15'h7FFF);
    send({24'h0, 24'h0, 24'h0, 24'hFFFFFF}, 4'hE, 1'b1);
    drain();
    chk("t4_masked", last_csc, 15'h0000);
    send({4{24'h7FFFFF}}, 4'h0, 1'b1);
    drain();
    chk("mask_zero", last_csc, 15'h0000);
    chk("no_overrun", overrun, 0);

    // Backpressure with an ignored sample offered mid-output.
    csc_data_rdy = 1'b0;
    send({24'h001000, 24'h000800, 24'hFFF000, 24'h003000}, 4'hB, 1'b1);
    exp5 = q[q.size()-1].sat;
    n = 0;
    while (!csc_data_en && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_en_seen", csc_data_en, 1);
    for (int i = 0; i < 10; i++) begin
      chk("t5_hold", csc_data, exp5);
      if (i == 3) begin
        vol_data  = {4{24'h100000}};
        chan_mask = 4'hF;
        data_en   = 1'b1;
      end
      if (i == 4) data_en = 1'b0;
      @(posedge clk); #1;
    end
    chk("t5_overrun", overrun, 1);
    csc_data_rdy = 1'b1;
    @(posedge clk); #1;
    chk("t5_in_ready", in_ready, 1);
    repeat (15) @(posedge clk);
    #1;
    drain();

    // Abort mid-accumulation with reset, then a clean transaction.
    send({4{24'h7FFFFF}}, 4'hF, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clip_model = 16'h0;
    chk("t6_in_ready", in_ready, 1);
    chk("t6_data_en", csc_data_en, 0);
    chk("t6_data", csc_data, 0);
    chk("t6_clip", clip_count, 0);
    chk("t6_overrun", overrun, 0);
    chk("t6_wrap_data", csc_data_w, 0);
    send({24'h0, 24'h0, 24'h000400, 24'h001000}, 4'h3, 1'b1);
    drain();
    chk("t6_fresh", last_csc, 15'd10);

    // Random traffic under random backpressure.
    rand_rdy = 1'b1;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 1) == 1) ch = 24'($urandom);
        else ch = 24'($signed($urandom_range(0, 16384)) - 8192);
        v[i*24 +: 24] = ch;
      end
      send(v, 4'($urandom_range(0, 15)), 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
    end
    drain();
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    csc_data_rdy = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    chk("out_count", out_count, pushed);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
